pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Consumer end of the hazard-detection interface: turns `hazard_detected`, the EX-stage branch/jump redirect and the data-memory busy signal into pipeline-register enables, flushes and bubbles.
- Sits between the hazard detection unit, branch resolution in EX, and the PC / IF-ID / ID-EX / EX-MEM registers.
- Adds multi-cycle squash after a redirect (registered instruction memory) and saturating performance counters.

Parameters:
- BRANCH_PENALTY, 1: extra squash cycles after the redirect cycle; range 0..15; 0 means the FLUSH state is never entered.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_detected  in  1  load-use/branch hazard request from the hazard detection unit (ID stage).
- branch_taken  in  1  EX-stage redirect (taken branch or jump); PC mux already selects the target.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- cnt_clr  in  1  synchronous clear of all counters.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID load NOP.
- idex_bubble  out  1  ID/EX load NOP (control bits zeroed).
- pipe_hold  out  1  EX/MEM and MEM/WB hold.
- ctrl_state  out  2  00 RUN, 01 FLUSH, 10 FREEZE.
- stall_cnt  out  CNT_W  cycles with a hazard stall applied.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.
- freeze_cnt  out  CNT_W  cycles with pipe_hold=1.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to RUN, flush counter `fcnt` to 0, all perf counters to 0.
  - While rst_n is low, outputs are forced: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, pipe_hold=0, ctrl_state=00.
- Outputs are Mealy (combinational from state and inputs), so each response takes effect in the same cycle. State, fcnt and counters update on the rising clk edge.
- Input priority per cycle: mem_busy > branch_taken > hazard_detected.
- mem_busy=1 (any state):
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, pipe_hold=1.
  - Next state FREEZE; fcnt is held. A branch_taken or hazard_detected in the same cycle is ignored and must be re-presented by its source.
- FREEZE with mem_busy=0: resume as if in FLUSH when fcnt≠0, else as if in RUN, and evaluate that cycle's inputs under that state's rules.
- RUN, branch_taken=1:
  - Outputs: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, pipe_hold=0.
  - Next: if BRANCH_PENALTY=0, stay RUN; otherwise go to FLUSH with fcnt=BRANCH_PENALTY.
- RUN, hazard_detected=1 (no branch): pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0. One stall per asserted cycle; the stall lasts exactly as long as the input is asserted.
- RUN, idle: pc_we=1, ifid_we=1, all others 0.
- FLUSH:
  - Outputs: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=0. hazard_detected is ignored (ID holds a wrong-path instruction).
  - fcnt decrements each cycle; when fcnt reaches 1 the next state is RUN with fcnt=0.
  - branch_taken=1 in FLUSH (defensive case) gives redirect outputs and reloads fcnt=BRANCH_PENALTY.
- Counters:
  - stall_cnt increments when a hazard stall is applied; flush_cnt when ifid_flush=1; freeze_cnt when pipe_hold=1.
  - Each saturates at 2^CNT_W−1 (no wrap).
  - cnt_clr=1 zeroes all counters, overriding any increment in the same cycle.
- ctrl_state reflects the registered state, except that it is forced to 00 during reset.

Test Plan:
- Reset applied mid-FLUSH (BRANCH_PENALTY=3, fcnt=2), asynchronously between edges -> outputs immediately forced to 0, ctrl_state=00; after release, idle gives pc_we=1 and all counters read 0.
- Load-use: hazard_detected=1 for 1 cycle, then 2 cycles -> pc_we=0, ifid_we=0, idex_bubble=1 in exactly those 3 cycles; stall_cnt=3.
- Branch with BRANCH_PENALTY=2 -> redirect cycle (ifid_flush=1, idex_bubble=1), then 2 FLUSH cycles (ifid_flush=1, idex_bubble=0), then RUN; flush_cnt=3. A hazard_detected pulse during the flush leaves stall_cnt at 0.
- mem_busy=1 for 4 cycles arriving in the 1st FLUSH cycle (BRANCH_PENALTY=2) -> pipe_hold=1 for 4 cycles, freeze_cnt=4, fcnt held at 2; afterwards 2 flush cycles, then RUN.
- Simultaneous mem_busy, branch_taken and hazard_detected in RUN -> freeze only, ctrl_state=10, stall_cnt and flush_cnt unchanged.
- CNT_W=4, hazard held 20 cycles -> stall_cnt saturates at 15. cnt_clr together with an active stall -> stall_cnt=0 on the next edge.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush/freeze controller: maps hazard, redirect and memory-busy
// requests onto pipeline-register enables, and counts stall/flush/freeze cycles.
module pipeline_stall_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    FREEZE = 2'b10
  } state_t;

  localparam logic [3:0]       PENALTY = 4'(BRANCH_PENALTY);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nx, eff_state;
  logic [3:0] fcnt, fcnt_nx;
  logic       stall_apply;

  // A freeze leaves the squash count untouched, so leaving FREEZE picks up
  // exactly where the interrupted flush (if any) stopped.
  assign eff_state = (state == FREEZE) ? ((fcnt != 4'd0) ? FLUSH : RUN) : state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    if (mem_busy) begin
      state_nx = FREEZE;
    end else if (branch_taken) begin
      if (PENALTY == 4'd0) begin
        state_nx = RUN;
        fcnt_nx  = 4'd0;
      end else begin
        state_nx = FLUSH;
        fcnt_nx  = PENALTY;
      end
    end else if (eff_state == FLUSH) begin
      if (fcnt <= 4'd1) begin
        state_nx = RUN;
        fcnt_nx  = 4'd0;
      end else begin
        state_nx = FLUSH;
        fcnt_nx  = fcnt - 4'd1;
      end
    end else begin
      state_nx = RUN;
    end
  end

  // Hazard requests are ignored while flushing: ID holds a wrong-path instruction.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    stall_apply = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pipe_hold = 1'b1;
      end else if (branch_taken) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (eff_state == FLUSH) begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b1;
      end else if (hazard_detected) begin
        idex_bubble = 1'b1;
        stall_apply = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end
  end

  assign ctrl_state = rst_n ? state : RUN;

  // Saturating counters; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_apply && stall_cnt != CNT_MAX)  stall_cnt  <= stall_cnt + CNT_ONE;
      if (ifid_flush && flush_cnt != CNT_MAX)   flush_cnt  <= flush_cnt + CNT_ONE;
      if (pipe_hold && freeze_cnt != CNT_MAX)   freeze_cnt <= freeze_cnt + CNT_ONE;
    end
  end

endmodule
